logicnet_pipe_ctrl: RTL and testbench
=====================================

# logicnet_pipe_ctrl

Flow controller for a pipelined LogicNet classifier. It sequences samples through `NUM_LAYERS` registered stages of combinational neuron LUT layers. The block owns the per-stage valid bits and register enables, collapses bubbles and propagates backpressure. A 2-entry output buffer decouples the last layer from the consumer. The LUT layers and inter-layer data registers sit outside this block; it drives only their enables.

## Interface
- `NUM_LAYERS`, default 4: number of registered LUT-layer stages, minimum 1.
- `OUT_BITS`, default 2: width of the final-layer output word.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous pipeline clear, same effect on control state as `rst`.
- `in_valid` input 1: upstream sample available.
- `in_ready` output 1: sample is accepted on an edge where `in_valid && in_ready`.
- `stage_en` output NUM_LAYERS: load enable for the stage-k data register. Bit 0 loads the layer-0 LUT result of the upstream sample.
- `stage_valid` output NUM_LAYERS: stage k register holds a live sample.
- `last_data` input OUT_BITS: output of the final stage register.
- `out_valid` output 1: buffer head valid.
- `out_ready` input 1: consumer accepts.
- `out_data` output OUT_BITS: buffer head word.
- `busy` output 1: any `stage_valid` bit set or buffer non-empty.

## Operation
- Valid bits `v[k]` and the buffer are registers. All other control signals are combinational from them and from the handshake inputs.
- Buffer push condition `bpush = v[N-1] && (count<2 || (out_valid && out_ready))`.
- Stage readiness:
  - Last stage: `rdy[N-1] = !v[N-1] || bpush`.
  - Other stages: `rdy[k] = !v[k] || stage_en[k+1]`.
- Stage enables:
  - `stage_en[0] = in_valid && rdy[0]`.
  - `stage_en[k] = v[k-1] && rdy[k]`, for k≥1.
  - `in_ready = rdy[0]`.
- Valid update on each edge: `v[k] <= stage_en[k] ? 1 : (rdy[k] ? 0 : v[k])`. A stage that empties with no new input clears its bit, which collapses bubbles.
- Buffer: 2-entry FIFO holding `last_data`, first-word fall-through.
  - `out_valid = count!=0`; `out_data` = head.
  - A push and pop in the same cycle are allowed when count is 1 or 2, and count is unchanged.
  - Pop when count is 0 is impossible.
- Ordering: samples leave in acceptance order. No sample is dropped or duplicated.
- `flush`: on that edge all `v` bits clear, the buffer empties and counters hold. Flush has priority over a same-edge handshake: an input presented that cycle is not accepted, and `in_ready` is forced to 0 while `flush` is high.
- `rst`: same as flush, and in addition `out_data` returns to 0 and counters return to 0.
- `N=1`: stage 0 feeds the buffer directly, with the same rules applying.

## Timing
- Reset values: `v`=0, count=0, `out_valid`=0, `out_data`=0, `busy`=0, `stage_en`=0 while `rst` is high. `in_ready`=0 while `rst` is high, and 1 on the first cycle after.
- Latency: a sample accepted on edge E is in stage k after edge E+k. It is pushed on edge E+N, so `out_valid` is high in the cycle after edge E+N. This gives N+1 edges including the accept edge, with no stalls.
- Throughput: 1 sample/cycle while `out_ready` is held high.
- Capacity: N+2 samples in flight. With `out_ready` low indefinitely, `in_ready` falls after exactly N+2 accepts.
- Backpressure path: `out_ready` → `bpush` → `rdy` chain → `in_ready` is combinational across all stages. This path is accepted for N ≤ 8.

## Configuration
- Macro `LOGICNET_PERF_CNT_EN`.
- Defined: adds output `sample_count[31:0]` and output `stall_count[31:0]`.
  - `sample_count` increments on each `out_valid && out_ready`.
  - `stall_count` increments on each cycle with `out_valid && !out_ready`.
  - Both saturate at 32'hFFFFFFFF, reset to 0 on `rst`, and are unaffected by `flush`.
- Undefined: both ports and their counter logic are absent. Control behaviour is identical.

## Test plan
- Reset then stream, N=4, `out_ready`=1, accept samples A,B,C on consecutive edges 0,1,2 → `out_valid` high after edges 4,5,6 with data A,B,C. `in_ready` stays 1 throughout.
- Full backpressure, `out_ready`=0, `in_valid`=1 → exactly 6 accepts, then `in_ready`=0. `stage_valid`=4'b1111 and `out_valid`=1. Releasing `out_ready` drains all 6 in order, one per cycle.
- Bubble collapse: accept one sample, idle 2 cycles, accept a second sample, with `out_ready`=0 → both samples pack into the buffer and `stage_valid` returns to 0.
- Full buffer, simultaneous push and pop: count=2, `v[3]`=1, `out_ready`=1 → pop and push on the same edge, count stays 2, no loss.
- Flush mid-stream with 3 samples in flight and `in_valid`=1 → next cycle `busy`=0 and `out_valid`=0. The flush-cycle input is not accepted, and no stale sample appears later.
- With `LOGICNET_PERF_CNT_EN`: 5 handshakes and 3 stall cycles → `sample_count`=5, `stall_count`=3. After `rst` both read 0.

Source files
------------

// File: rtl/logicnet_pipe_ctrl.sv
// logicnet_pipe_ctrl
// Flow controller for a pipelined LogicNet classifier. It owns the per-stage
// valid bits and load enables of NUM_LAYERS registered LUT-layer stages. It
// collapses bubbles and propagates backpressure from a 2-entry
// first-word-fall-through output buffer.
// Optional feature: define LOGICNET_PERF_CNT_EN to add the saturating
// sample_count / stall_count performance counters.
module logicnet_pipe_ctrl #(
    parameter int NUM_LAYERS = 4,
    parameter int OUT_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NUM_LAYERS-1:0] stage_en,
    output logic [NUM_LAYERS-1:0] stage_valid,
    input  logic [OUT_BITS-1:0]   last_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_BITS-1:0]   out_data,
    output logic                  busy
`ifdef LOGICNET_PERF_CNT_EN
    ,
    output logic [31:0]           sample_count,
    output logic [31:0]           stall_count
`endif
);

    logic [NUM_LAYERS-1:0] r_v;
    logic [1:0]            r_count;
    logic [OUT_BITS-1:0]   r_head;
    logic [OUT_BITS-1:0]   r_tail;

    logic                  w_hold;
    logic                  w_pop;
    logic                  w_bpush;
    logic [NUM_LAYERS-1:0] w_src;
    logic [NUM_LAYERS-1:0] w_rdy;
    logic [NUM_LAYERS:0]   w_en;

    // rst and flush both freeze the handshakes for the cycle they are high.
    assign w_hold  = rst | flush;
    assign w_pop   = (r_count != 2'd0) && out_ready;
    assign w_bpush = r_v[NUM_LAYERS-1] && ((r_count < 2'd2) || w_pop);

    // Each stage is fed by the stage before it; stage 0 is fed by the upstream
    // port, which is ignored while the pipeline is being cleared.
    generate
        if (NUM_LAYERS == 1) begin : g_src_single
            assign w_src = in_valid && !w_hold;
        end else begin : g_src_multi
            assign w_src = {r_v[NUM_LAYERS-2:0], in_valid && !w_hold};
        end
    endgenerate

    // Ready/enable chain from the buffer back towards the input; bit
    // NUM_LAYERS of the enable vector stands for the buffer push.
    always_comb begin
        logic [NUM_LAYERS:0]   en_v;
        logic [NUM_LAYERS-1:0] rdy_v;
        en_v             = '0;
        rdy_v            = '0;
        en_v[NUM_LAYERS] = w_bpush;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            rdy_v[k] = !r_v[k] || en_v[k+1];
            en_v[k]  = w_src[k] && rdy_v[k];
        end
        w_rdy = rdy_v;
        w_en  = en_v;
    end

    // Enables and input readiness are forced off while the pipeline is being cleared.
    always_comb begin
        if (w_hold) begin
            in_ready = 1'b0;
            stage_en = '0;
        end else begin
            in_ready = w_rdy[0];
            stage_en = w_en[NUM_LAYERS-1:0];
        end
    end

    assign stage_valid = r_v;
    assign out_valid   = (r_count != 2'd0);
    assign out_data    = r_head;
    assign busy        = (|r_v) || (r_count != 2'd0);

    // Stage valid bits: load when enabled, clear when drained with no refill.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (w_en[k]) begin
                    r_v[k] <= 1'b1;
                end else if (w_rdy[k]) begin
                    r_v[k] <= 1'b0;
                end else begin
                    r_v[k] <= r_v[k];
                end
            end
        end
    end

    // Two-entry output FIFO; head register drives out_data directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_bpush, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= last_data;
                    end else begin
                        r_tail <= last_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= last_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= last_data;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

`ifdef LOGICNET_PERF_CNT_EN
    logic [31:0] r_sample_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating handshake and stall counters; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_cnt <= 32'd0;
            r_stall_cnt  <= 32'd0;
        end else begin
            if (out_valid && out_ready && (r_sample_cnt != 32'hFFFF_FFFF)) begin
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end else begin
                r_sample_cnt <= r_sample_cnt;
            end
            if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign sample_count = r_sample_cnt;
    assign stall_count  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_logicnet_pipe_ctrl.sv
// Testbench for logicnet_pipe_ctrl (NUM_LAYERS=4, 8-bit data). The external
// LUT data registers are emulated as a plain shift chain gated by stage_en.
// A queue-based model tracks the samples in flight by acceptance edge.
module tb_logicnet_pipe_ctrl;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid, busy;
    logic [N-1:0] stage_en, stage_valid;
    logic [W-1:0] last_data, out_data;
`ifdef LOGICNET_PERF_CNT_EN
    logic [31:0]  sample_count, stall_count;
`endif

    logicnet_pipe_ctrl #(.NUM_LAYERS(N), .OUT_BITS(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .stage_en(stage_en), .stage_valid(stage_valid),
        .last_data(last_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
`ifdef LOGICNET_PERF_CNT_EN
        , .sample_count(sample_count), .stall_count(stall_count)
`endif
    );

    // Environment: data registers loaded by stage_en.
    logic [W-1:0] d [N];
    always @(posedge clk) begin
        if (stage_en[0]) d[0] <= in_data;
        for (int k = 1; k < N; k++) if (stage_en[k]) d[k] <= d[k-1];
    end
    assign last_data = d[N-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: samples in flight in acceptance order with their accept edge.
    int q_d[$];
    int q_e[$];
    int last_edge = 0;
    bit m_ov, m_ir;
    logic [31:0] exp_sc = 32'd0;
    logic [31:0] exp_st = 32'd0;

    always @(negedge clk) begin
`ifdef LOGICNET_PERF_CNT_EN
        chk("sample_count", sample_count, exp_sc);
        chk("stall_count", stall_count, exp_st);
`endif
        if (rst) begin
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_stage_en", stage_en, 4'd0);
            q_d.delete();
            q_e.delete();
            exp_sc = 32'd0;
            exp_st = 32'd0;
        end else begin
            m_ov = 1'b0;
            if (q_d.size() > 0) m_ov = (q_e[0] + N <= last_edge);
            m_ir = !flush && !((q_d.size() == N + 2) && !out_ready);
            chk("in_ready", in_ready, m_ir);
            chk("out_valid", out_valid, m_ov);
            chk("busy", busy, q_d.size() > 0);
            chk("stage_en0", stage_en[0], in_valid && m_ir);
            if (m_ov) chk("out_data", out_data, q_d[0][W-1:0]);
            if (m_ov && out_ready && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
            if (m_ov && !out_ready && exp_st != 32'hFFFF_FFFF) exp_st = exp_st + 32'd1;
            if (flush) begin
                q_d.delete();
                q_e.delete();
            end else begin
                if (m_ov && out_ready) begin
                    void'(q_d.pop_front());
                    void'(q_e.pop_front());
                end
                if (in_valid && m_ir) begin
                    q_d.push_back(int'(in_data));
                    q_e.push_back(last_edge + 1);
                end
            end
        end
        last_edge++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    int acc;
    int t;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        tick(); tick();
        chk("rst_in_ready_lit", in_ready, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_stage_valid", stage_valid, 4'h0);

        // Stream A,B,C with the consumer always ready.
        in_valid = 1'b1; in_data = 8'hA1;
        tick(); chk("stream_ir1", in_ready, 1'b1); in_data = 8'hB2;
        tick(); chk("stream_ir2", in_ready, 1'b1); in_data = 8'hC3;
        tick(); in_valid = 1'b0;
        tick(); chk("stream_not_yet", out_valid, 1'b0);
        tick(); chk("stream_A_v", out_valid, 1'b1); chk("stream_A", out_data, 8'hA1);
        tick(); chk("stream_B", out_data, 8'hB2);
        tick(); chk("stream_C", out_data, 8'hC3);
        tick(); chk("stream_done", out_valid, 1'b0);

        // Full backpressure: capacity is N+2.
        out_ready = 1'b0; in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 12; i++) begin
            in_data = W'(8'h10 + acc);
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("bp_accepts", acc, 6);
        chk("bp_stage_valid", stage_valid, 4'hF);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_head", out_data, 8'h10);
        // Release: first edge pops and pushes with the buffer full.
        out_ready = 1'b1;
        tick();
        chk("pushpop_stage_valid", stage_valid, 4'hE);
        for (int i = 1; i < 6; i++) begin
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_data", out_data, W'(8'h10 + i));
            tick();
        end
        chk("drain_empty", busy, 1'b0);

        // Bubble collapse.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h21;
        tick(); in_valid = 1'b0;
        tick(); tick();
        in_valid = 1'b1; in_data = 8'h22;
        tick(); in_valid = 1'b0;
        repeat (6) tick();
        chk("bubble_stage_valid", stage_valid, 4'h0);
        chk("bubble_head", out_data, 8'h21);
        out_ready = 1'b1;
        tick(); chk("bubble_second", out_data, 8'h22);
        tick(); chk("bubble_empty", out_valid, 1'b0);

        // Flush with three samples in flight.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = W'(8'h31 + i);
            tick();
        end
        flush = 1'b1; in_data = 8'h34;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_busy", busy, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        repeat (8) tick();
        chk("flush_no_stale", out_valid, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            in_data   = W'($urandom);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        t = 0;
        while (busy && t < 50) begin tick(); t++; end
        chk("random_drain", busy, 1'b0);

`ifdef LOGICNET_PERF_CNT_EN
        rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
        chk("cnt_rst_sample", sample_count, 32'd0);
        chk("cnt_rst_stall", stall_count, 32'd0);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin in_data = W'(8'h50 + i); tick(); end
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin tick(); t++; end
        chk("cnt_first_out", out_valid, 1'b1);
        repeat (3) tick();
        out_ready = 1'b1;
        t = 0;
        while (busy && t < 30) begin tick(); t++; end
        chk("cnt_sample", sample_count, 32'd5);
        chk("cnt_stall", stall_count, 32'd3);
        rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
        chk("cnt_rst2_sample", sample_count, 32'd0);
        chk("cnt_rst2_stall", stall_count, 32'd0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
